fir_coef_bank: RTL

//  Multi-filter, double-buffered FIR coefficient store. Host loads coefficients byte-serially into a

---
 rtl/fir_coef_bank_pkg.sv | 36 +++
 rtl/fir_coef_bank_if.sv | 34 +++
 rtl/fir_coef_dpram.sv | 35 +++
 rtl/fir_coef_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fir_coef_bank_pkg.sv
// Shared constants, types and helpers for the FIR coefficient bank.
package fir_coef_bank_pkg;

    localparam int COEF_W      = 16;
    localparam int MAX_TAPS    = 256;
    localparam int NUM_FILTERS = 4;

    localparam int NB     = COEF_W / 8;
    localparam int TAP_W  = $clog2(MAX_TAPS);
    localparam int FSEL_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int BCNT_W = (NB > 1) ? $clog2(NB) : 1;
    // One bank bit on top of filter and tap index.
    localparam int RAM_AW = 1 + FSEL_W + TAP_W;

    typedef logic [COEF_W-1:0] coef_t;
    typedef logic [TAP_W-1:0]  tap_idx_t;
    typedef logic [TAP_W:0]    tap_cnt_t;
    typedef logic [FSEL_W-1:0] fsel_t;
    typedef logic [RAM_AW-1:0] ram_addr_t;

    // LOAD accepts bytes; PENDING waits for the sample strobe to swap banks.
    typedef enum logic {
        ST_LOAD    = 1'b0,
        ST_PENDING = 1'b1
    } load_state_t;

    function automatic ram_addr_t ram_addr(input logic bank, input fsel_t fsel, input tap_idx_t tap);
        return {bank, fsel, tap};
    endfunction

    // Filter selects past the last implemented filter are treated as absent.
    function automatic logic fsel_ok(input fsel_t fsel);
        return {1'b0, fsel} < (FSEL_W + 1)'(NUM_FILTERS);
    endfunction

endpackage

// File: rtl/fir_coef_bank_if.sv
// Host/datapath-side signal bundle of the coefficient bank.
interface fir_coef_bank_if;
    import fir_coef_bank_pkg::*;

    tap_cnt_t               taps_per_filter;
    fsel_t                  wr_filter_sel;
    logic                   wr_byte_valid;
    logic [7:0]             wr_byte;
    logic                   coef_rst;
    logic                   commit_req;
    logic                   sample_strobe;
    logic                   rd_en;
    fsel_t                  rd_filter_sel;
    tap_idx_t               rd_addr;
    coef_t                  coef_out;
    logic                   coef_valid;
    logic                   wr_addr_zero;
    logic                   load_done;
    logic                   wr_busy;
    logic [NUM_FILTERS-1:0] active_bank;

    modport master (
        output taps_per_filter, wr_filter_sel, wr_byte_valid, wr_byte, coef_rst,
               commit_req, sample_strobe, rd_en, rd_filter_sel, rd_addr,
        input  coef_out, coef_valid, wr_addr_zero, load_done, wr_busy, active_bank
    );

    modport slave (
        input  taps_per_filter, wr_filter_sel, wr_byte_valid, wr_byte, coef_rst,
               commit_req, sample_strobe, rd_en, rd_filter_sel, rd_addr,
        output coef_out, coef_valid, wr_addr_zero, load_done, wr_busy, active_bank
    );

endinterface

// File: rtl/fir_coef_dpram.sv
// Simple dual-port RAM: one write port, one synchronous read port with
// a one-cycle latency; written so synthesis maps it onto block RAM.
module fir_coef_dpram #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; output holds when no read is requested.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fir_coef_bank.sv
// Double-buffered multi-filter FIR coefficient store: byte-serial shadow
// loading, commit-on-sample-boundary bank swap, registered coefficient read.
module fir_coef_bank
    import fir_coef_bank_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    fir_coef_bank_if.slave bus
);

    load_state_t            r_state;
    fsel_t                  r_pend_fsel;
    logic [NUM_FILTERS-1:0] r_active_bank;
    tap_idx_t               r_tap;
    logic [BCNT_W-1:0]      r_byte_cnt;
    fsel_t                  r_wr_fsel;
    logic                   r_load_done;
    logic                   r_coef_valid;
    logic                   r_rd_zero;

    tap_cnt_t               w_n_eff;
    logic                   w_last_tap;
    fsel_t                  w_wr_fsel;
    coef_t                  w_shift;
    logic                   w_commit_live;
    fsel_t                  w_commit_fsel;
    logic                   w_swap;
    logic                   w_byte_acc;
    logic                   w_word_done;
    logic                   w_we;
    ram_addr_t              w_waddr;
    ram_addr_t              w_raddr;
    logic                   w_re;
    coef_t                  w_ram_q;
    logic [NUM_FILTERS-1:0] w_bank_toggle;

    // A tap count of 0 (or anything past the maximum) means the full table.
    assign w_n_eff = (bus.taps_per_filter == '0 || bus.taps_per_filter > tap_cnt_t'(MAX_TAPS))
                   ? tap_cnt_t'(MAX_TAPS) : bus.taps_per_filter;
    // Compared one bit wider so N = MAX_TAPS still reaches the top index.
    assign w_last_tap = ({1'b0, r_tap} == (w_n_eff - tap_cnt_t'(1)));

    // The destination filter is latched by the first byte of each word.
    assign w_wr_fsel = (r_byte_cnt == '0) ? bus.wr_filter_sel : r_wr_fsel;

    // A commit is live while pending, or in the very cycle it is requested.
    assign w_commit_live = (r_state == ST_PENDING) ||
                           (bus.commit_req && fsel_ok(bus.wr_filter_sel));
    assign w_commit_fsel = (r_state == ST_PENDING) ? r_pend_fsel : bus.wr_filter_sel;
    assign w_swap        = bus.sample_strobe && w_commit_live;

    // Swap cycle and restart both outrank an incoming byte.
    assign w_byte_acc  = bus.wr_byte_valid && (r_state == ST_LOAD) && !bus.coef_rst && !w_swap;
    assign w_word_done = w_byte_acc && (r_byte_cnt == BCNT_W'(NB - 1));
    assign w_we        = w_word_done && fsel_ok(w_wr_fsel);
    assign w_waddr     = ram_addr(~r_active_bank[w_wr_fsel], w_wr_fsel, r_tap);

    // Bytes arrive LSB first, so each new byte enters at the top of the word.
    generate
        if (NB == 1) begin : g_asm_single
            assign w_shift = bus.wr_byte;
        end else begin : g_asm_multi
            logic [COEF_W-9:0] r_asm;

            // Holds the bytes of the word received so far.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_asm <= '0;
                end else if (w_byte_acc) begin
                    r_asm <= w_shift[COEF_W-1:8];
                end
            end

            assign w_shift = {bus.wr_byte, r_asm};
        end
    endgenerate

    // One toggle request per filter, raised only in the swap cycle.
    generate
        for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_bank_toggle
            assign w_bank_toggle[gi] = w_swap && (w_commit_fsel == fsel_t'(gi));
        end
    endgenerate

    // Commit FSM plus the per-filter active-bank bits it controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_LOAD;
            r_pend_fsel   <= '0;
            r_active_bank <= '0;
        end else begin
            r_active_bank <= r_active_bank ^ w_bank_toggle;
            case (r_state)
                ST_LOAD: begin
                    // A request coinciding with the strobe swaps immediately.
                    if (bus.commit_req && fsel_ok(bus.wr_filter_sel) && !bus.sample_strobe) begin
                        r_state     <= ST_PENDING;
                        r_pend_fsel <= bus.wr_filter_sel;
                    end
                end
                ST_PENDING: begin
                    if (bus.sample_strobe) begin
                        r_state <= ST_LOAD;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    // Shadow load pointer: byte counter, tap address and end-of-set pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tap       <= '0;
            r_byte_cnt  <= '0;
            r_wr_fsel   <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            if (bus.coef_rst || w_swap) begin
                r_tap      <= '0;
                r_byte_cnt <= '0;
            end else if (w_byte_acc) begin
                if (r_byte_cnt == '0) begin
                    r_wr_fsel <= bus.wr_filter_sel;
                end
                if (w_word_done) begin
                    r_byte_cnt  <= '0;
                    r_tap       <= w_last_tap ? '0 : r_tap + tap_idx_t'(1);
                    r_load_done <= w_last_tap;
                end else begin
                    r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
                end
            end
        end
    end

    // Reads always target the active bank as it stood before any same-cycle swap.
    assign w_re    = bus.rd_en && fsel_ok(bus.rd_filter_sel);
    assign w_raddr = ram_addr(r_active_bank[bus.rd_filter_sel], bus.rd_filter_sel, bus.rd_addr);

    // Read qualifiers; the zero flag masks reset and absent-filter reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_coef_valid <= 1'b0;
            r_rd_zero    <= 1'b1;
        end else begin
            r_coef_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_zero <= !fsel_ok(bus.rd_filter_sel);
            end
        end
    end

    fir_coef_dpram #(
        .AW (RAM_AW),
        .DW (COEF_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_shift),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_q)
    );

    assign bus.coef_out     = r_rd_zero ? '0 : w_ram_q;
    assign bus.coef_valid   = r_coef_valid;
    assign bus.wr_addr_zero = (r_tap == '0) && (r_byte_cnt == '0);
    assign bus.load_done    = r_load_done;
    assign bus.wr_busy      = (r_state == ST_PENDING);
    assign bus.active_bank  = r_active_bank;

endmodule
